platform_motion_ctrl: RTL and testbench

- Frame-synchronous controller that sequences horizontal motion of the game platforms.
- Owns the live platform X coordinates and per-platform frame deltas; feeds them to the platform renderer/collision block and to the character block, so a character standing on a platform is carried with it.
- Updates happen only on the rising edge of vertical blanking, one platform per clock, so the renderer never sees positions change mid-frame.

---
 rtl/platform_motion_ctrl.sv | 158 +++++++++++++++
 tb/tb_platform_motion_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_motion_ctrl.sv
// Frame-synchronous platform motion sequencer: on each qualifying vblnk rise it sweeps
// the platforms one per clock, updating X and the per-frame delta. INIT_X holds platform i at [12*i+11:12*i].
module platform_motion_ctrl #(
  parameter int                        PLAT_COUNT = 4,
  parameter int                        SCREEN_W   = 1024,
  parameter int                        PLAT_WIDTH = 204,
  parameter int                        SPEED      = 2,
  parameter int                        FRAME_DIV  = 1,
  parameter logic [PLAT_COUNT-1:0]     MOVE_MASK  = 4'b0100,
  parameter logic [12*PLAT_COUNT-1:0]  INIT_X     = {12'd0, 12'd410, 12'd820, 12'd0}
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  game_active,
  input  logic                        vblnk,
  output logic [12*PLAT_COUNT-1:0]    plat_x,
  output logic [4*PLAT_COUNT-1:0]     plat_dx,
  output logic                        update_busy,
  output logic                        update_done
);

  localparam int IW = (PLAT_COUNT > 1) ? $clog2(PLAT_COUNT) : 1;
  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [12:0] BOUND = 13'(SCREEN_W - PLAT_WIDTH);
  localparam logic [12:0] STEP  = 13'(SPEED);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_vblnk_q;
  logic [CW-1:0]      r_cnt;
  logic [IW-1:0]      r_idx;
  logic [11:0]        r_x    [PLAT_COUNT];
  logic signed [3:0]  r_dx   [PLAT_COUNT];
  logic               r_left [PLAT_COUNT];
  logic               r_busy, r_done;

  logic               w_rise, w_frame_hit, w_last, w_playing;
  logic               w_tick, w_start, w_step, w_finish;
  logic               w_moves, w_flip;
  logic [12:0]        w_old, w_sum, w_new;
  logic signed [12:0] w_diff;
  logic signed [3:0]  w_dx_sat;

  assign w_rise      = vblnk & ~r_vblnk_q;
  assign w_playing   = (game_active == 2'd1);
  assign w_frame_hit = (r_cnt == CW'(FRAME_DIV - 1));
  assign w_last      = (r_idx == IW'(PLAT_COUNT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_playing) w_state_nxt = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:   if (w_rise && w_frame_hit) w_state_nxt = S_UPDATE;
        S_UPDATE: if (w_last) w_state_nxt = S_DONE;
        S_DONE:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_tick   = 1'b0;
    w_start  = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    if (w_playing) begin
      case (r_state)
        S_IDLE:   begin w_tick = w_rise; w_start = w_rise && w_frame_hit; end
        S_UPDATE: w_step = 1'b1;
        S_DONE:   w_finish = 1'b1;
        default:  ;
      endcase
    end
  end

  // Step for the platform at r_idx, 13-bit so neither bound test can wrap.
  always_comb begin
    w_old   = {1'b0, r_x[r_idx]};
    w_moves = MOVE_MASK[r_idx] && !w_last;
    w_sum   = w_old + STEP;
    w_new   = w_old;
    w_flip  = 1'b0;
    if (w_moves) begin
      if (!r_left[r_idx]) begin
        if (w_sum >= BOUND) begin w_new = BOUND; w_flip = 1'b1; end
        else                      w_new = w_sum;
      end else begin
        if (w_old <= STEP) begin w_new = '0; w_flip = 1'b1; end
        else                     w_new = w_old - STEP;
      end
    end
    w_diff = $signed(w_new) - $signed(w_old);
    if (w_diff > 13'sd7)       w_dx_sat = 4'sd7;
    else if (w_diff < -13'sd8) w_dx_sat = -4'sd8;
    else                       w_dx_sat = w_diff[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vblnk_q <= 1'b0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      for (int unsigned i = 0; i < PLAT_COUNT; i++) begin
        r_x[i]    <= INIT_X[12*i +: 12];
        r_dx[i]   <= '0;
        r_left[i] <= 1'b0;
      end
    end else begin
      r_vblnk_q <= vblnk;
      r_done    <= 1'b0;
      if (game_active == 2'd0) begin
        r_cnt  <= '0;
        r_busy <= 1'b0;
        for (int unsigned i = 0; i < PLAT_COUNT; i++) begin
          r_x[i]    <= INIT_X[12*i +: 12];
          r_dx[i]   <= '0;
          r_left[i] <= 1'b0;
        end
      end else if (!w_playing) begin
        r_busy <= 1'b0;
        for (int unsigned i = 0; i < PLAT_COUNT; i++) r_dx[i] <= '0;
      end else begin
        if (w_tick) r_cnt <= w_frame_hit ? '0 : r_cnt + 1'b1;
        if (w_start) begin
          r_idx  <= '0;
          r_busy <= 1'b1;
        end
        if (w_step) begin
          r_x[r_idx]  <= w_new[11:0];
          r_dx[r_idx] <= w_dx_sat;
          if (w_flip) r_left[r_idx] <= ~r_left[r_idx];
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        if (w_finish) begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < PLAT_COUNT; g++) begin : g_out
    assign plat_x[12*g +: 12] = r_x[g];
    assign plat_dx[4*g +: 4]  = r_dx[g];
  end
  assign update_busy = r_busy;
  assign update_done = r_done;

endmodule

// File: tb/tb_platform_motion_ctrl.sv
// Bench for platform_motion_ctrl: four differently parameterised instances share stimulus
// and are compared against a frame-level model of the platform motion rules.
module tb_platform_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  ga = 2'd0;
  logic        vblnk = 1'b0;
  logic [47:0] px   [4];
  logic [15:0] pdx  [4];
  logic        busy [4];
  logic        done [4];

  int          n_checks = 0;
  int          n_errors = 0;

  int          mw [4];
  int          fd [4];
  logic [3:0]  mask [4];
  logic [47:0] initx [4];
  int          mx [4][4];
  int          mdx [4][4];
  bit          mleft [4][4];
  int          mcnt [4];
  int          done_tot [4];

  always #5 clk = ~clk;

  platform_motion_ctrl u_d0 (
    .clk(clk), .rst(rst), .game_active(ga), .vblnk(vblnk),
    .plat_x(px[0]), .plat_dx(pdx[0]), .update_busy(busy[0]), .update_done(done[0]));
  platform_motion_ctrl #(.MOVE_MASK(4'b1111), .INIT_X({12'd0, 12'd819, 12'd1, 12'd0})) u_d1 (
    .clk(clk), .rst(rst), .game_active(ga), .vblnk(vblnk),
    .plat_x(px[1]), .plat_dx(pdx[1]), .update_busy(busy[1]), .update_done(done[1]));
  platform_motion_ctrl #(.FRAME_DIV(3)) u_d2 (
    .clk(clk), .rst(rst), .game_active(ga), .vblnk(vblnk),
    .plat_x(px[2]), .plat_dx(pdx[2]), .update_busy(busy[2]), .update_done(done[2]));
  platform_motion_ctrl #(.SCREEN_W(1023), .INIT_X({12'd0, 12'd818, 12'd820, 12'd0})) u_d3 (
    .clk(clk), .rst(rst), .game_active(ga), .vblnk(vblnk),
    .plat_x(px[3]), .plat_dx(pdx[3]), .update_busy(busy[3]), .update_done(done[3]));

  task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] gx(input int k, input int p);
    return {20'b0, px[k][12*p +: 12]};
  endfunction

  function automatic logic signed [31:0] gdx(input int k, input int p);
    logic signed [3:0] t;
    t = pdx[k][4*p +: 4];
    return t;
  endfunction

  function automatic void m_reload(input int k);
    for (int p = 0; p < 4; p++) begin
      mx[k][p]    = int'(initx[k][12*p +: 12]);
      mdx[k][p]   = 0;
      mleft[k][p] = 1'b0;
    end
    mcnt[k] = 0;
  endfunction

  function automatic void m_move(input int k, input int p);
    int ox, nx, d;
    ox = mx[k][p];
    nx = ox;
    if (mask[k][p] && p != 3) begin
      if (!mleft[k][p]) begin
        if (ox + 2 >= mw[k]) begin nx = mw[k]; mleft[k][p] = 1'b1; end
        else nx = ox + 2;
      end else begin
        if (ox <= 2) begin nx = 0; mleft[k][p] = 1'b0; end
        else nx = ox - 2;
      end
    end
    d = nx - ox;
    mdx[k][p] = (d > 7) ? 7 : ((d < -8) ? -8 : d);
    mx[k][p]  = nx;
  endfunction

  function automatic bit m_frame(input int k, input int nproc);
    if (mcnt[k] != fd[k] - 1) begin
      mcnt[k]++;
      return 1'b0;
    end
    mcnt[k] = 0;
    for (int p = 0; p < nproc; p++) m_move(k, p);
    return 1'b1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < 4; p++) begin
        check_eq($sformatf("d%0d.x%0d", k, p), gx(k, p), mx[k][p]);
        check_eq($sformatf("d%0d.dx%0d", k, p), gdx(k, p), mdx[k][p]);
      end
  endtask

  // Called at #1 after a posedge; leaves the bench at #1 after a posedge.
  task automatic run_frame(input int hold, input bit dbl, input int abort_at, input int gap);
    bit sw [4];
    int nd [4];
    int old2, new2, nproc, n;
    old2  = mx[0][2];
    nproc = (abort_at > 0) ? abort_at - 1 : 4;
    for (int k = 0; k < 4; k++) begin
      sw[k] = m_frame(k, nproc);
      nd[k] = 0;
    end
    if (abort_at > 0)
      for (int k = 0; k < 4; k++)
        for (int p = 0; p < 4; p++) mdx[k][p] = 0;
    new2 = mx[0][2];
    n = (abort_at > 0) ? abort_at + 8 : (((hold + 1 > 8) ? hold + 1 : 8) + gap);
    vblnk = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) if (done[k] === 1'b1) nd[k]++;
      if (c == hold) vblnk = 1'b0;
      if (dbl && c == 2) vblnk = 1'b1;
      if (dbl && c == 3) vblnk = 1'b0;
      if (abort_at > 0 && c == abort_at) ga = 2'd2;
      if (abort_at == 0) begin
        if (c == 1) check_eq("busy_start", busy[0], 1);
        if (c == 3) check_eq("x2_before", gx(0, 2), old2);
        if (c == 4) check_eq("x2_after", gx(0, 2), new2);
        if (c == 5) check_eq("done_early", done[0], 0);
        if (c == 6) begin
          check_eq("done_lat", done[0], 1);
          check_eq("busy_end", busy[0], 0);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("d%0d.done_cnt", k), nd[k], (abort_at == 0 && sw[k]) ? 1 : 0);
      done_tot[k] += nd[k];
      if (abort_at > 0) check_eq($sformatf("d%0d.abort_busy", k), busy[k], 0);
    end
    compare_all();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    int  hold, gap;
    bit  dbl, w1, w2;
    mw[0] = 820; mw[1] = 820; mw[2] = 820; mw[3] = 819;
    fd[0] = 1;   fd[1] = 1;   fd[2] = 3;   fd[3] = 1;
    mask[0] = 4'b0100; mask[1] = 4'b1111; mask[2] = 4'b0100; mask[3] = 4'b0100;
    initx[0] = {12'd0, 12'd410, 12'd820, 12'd0};
    initx[1] = {12'd0, 12'd819, 12'd1, 12'd0};
    initx[2] = {12'd0, 12'd410, 12'd820, 12'd0};
    initx[3] = {12'd0, 12'd818, 12'd820, 12'd0};
    for (int k = 0; k < 4; k++) begin m_reload(k); done_tot[k] = 0; end

    #1 rst = 1'b1;
    #2;
    compare_all();
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("d%0d.rst_busy", k), busy[k], 0);
      check_eq($sformatf("d%0d.rst_done", k), done[k], 0);
    end
    tick(3);
    rst = 1'b0;
    tick(2);
    ga = 2'd1;
    tick(1);

    // Directed opening frames: first step, right-wall flip, held vblnk, rise during a sweep.
    run_frame(1, 1'b0, 0, 2);
    check_eq("d0_first_x2", gx(0, 2), 412);
    check_eq("d0_first_dx2", gdx(0, 2), 2);
    check_eq("d1_wall_x2", gx(1, 2), 820);
    check_eq("d1_wall_dx2", gdx(1, 2), 1);
    run_frame(1, 1'b0, 0, 0);
    check_eq("d1_back_x2", gx(1, 2), 818);
    check_eq("d1_back_dx2", gdx(1, 2), -2);
    run_frame(2, 1'b0, 0, 1);
    run_frame(1, 1'b0, 0, 0);
    run_frame(50, 1'b0, 0, 0);
    run_frame(1, 1'b1, 0, 2);
    check_eq("d2_div3_x2", gx(2, 2), 414);
    check_eq("d2_div3_sweeps", done_tot[2], 2);

    // Long randomised run; carries d3 platform 2 down to the left wall.
    w2 = 1'b0;
    for (int f = 0; f < 430; f++) begin
      dbl  = (mcnt[2] == fd[2] - 1) && ($urandom_range(0, 3) == 0);
      hold = dbl ? 1 : (($urandom_range(0, 15) == 0) ? 50 : int'($urandom_range(1, 4)));
      gap  = $urandom_range(0, 3);
      w1   = (mx[3][2] == 1) && mleft[3][2];
      run_frame(hold, dbl, 0, gap);
      if (w1) begin
        check_eq("d3_lwall_x2", gx(3, 2), 0);
        check_eq("d3_lwall_dx2", gdx(3, 2), -1);
        w2 = 1'b1;
      end else if (w2) begin
        check_eq("d3_bounce_x2", gx(3, 2), 2);
        w2 = 1'b0;
      end
    end

    // Aborted sweeps, frozen game-over behaviour, optional reload.
    for (int a = 0; a < 8; a++) begin
      run_frame(1, 1'b0, int'($urandom_range(1, 5)), 0);
      repeat (2) begin
        vblnk = 1'b1; tick(2);
        vblnk = 1'b0; tick(2);
      end
      for (int k = 0; k < 4; k++) check_eq($sformatf("d%0d.frozen_done", k), done[k], 0);
      compare_all();
      if ($urandom_range(0, 1) == 1) begin
        ga = 2'd0;
        tick(2);
        for (int k = 0; k < 4; k++) m_reload(k);
        compare_all();
      end
      ga = 2'd1;
      tick(1);
      for (int f = 0; f < 3; f++) run_frame(int'($urandom_range(1, 3)), 1'b0, 0, int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of a sweep.
    vblnk = 1'b1; tick(1);
    vblnk = 1'b0; tick(2);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      m_reload(k);
      check_eq($sformatf("d%0d.arst_busy", k), busy[k], 0);
      check_eq($sformatf("d%0d.arst_done", k), done[k], 0);
    end
    compare_all();
    tick(2);
    rst = 1'b0;
    tick(1);
    for (int f = 0; f < 5; f++) run_frame(int'($urandom_range(1, 4)), 1'b0, 0, int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
